// File: rtl/matrix_scan_param.sv
// matrix_scan_param: HUB75-style row / bit-plane scanner for a COLUMNS x ROWS
// panel with BITS-deep binary-code-modulated bit-planes. Every output is a
// register in the clk_in domain; no clock is gated or derived.
//
// The shift of plane N overlaps the display of plane N-1. A plane is latched
// only after the previous display has finished and a blanking gap has passed.
//
// Optional feature (compile-time macro MATRIX_SCAN_DIM_EN):
//   adds a 2-bit 'dim' input that is sampled at LATCH exit. The on-time then
//   becomes (BASE_TICKS<<plane)>>dim, with a floor of 1 cycle.
//
// Ports:
//   clk_in                 in   system clock
//   reset                  in   asynchronous, active-high
//   enable                 in   permits scanning (sampled in IDLE / WAIT exit)
//   dim                    in   [1:0] brightness divider (MATRIX_SCAN_DIM_EN only)
//   column_address         out  column currently being shifted
//   row_address            out  row whose data is being shifted
//   row_address_active     out  row driven to the panel address lines
//   brightness_mask        out  one-hot plane being shifted
//   brightness_mask_active out  one-hot plane being displayed (0 = none)
//   pixel_load             out  request: upstream presents column data next cycle
//   clk_pixel              out  panel shift clock
//   row_latch              out  panel LAT
//   output_enable          out  high = LEDs lit
//   frame_start            out  pulse with first OE cycle of row 0, top plane
module matrix_scan_param #(
  parameter int COLUMNS      = 64,
  parameter int ROWS         = 16,
  parameter int BITS         = 6,
  parameter int BASE_TICKS   = 23,
  parameter int LATCH_CYCLES = 1,
  parameter int BLANK_CYCLES = 1,
  localparam int COL_W = $clog2(COLUMNS),
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
`ifdef MATRIX_SCAN_DIM_EN
  input  logic [1:0]       dim,
`endif
  output logic [COL_W-1:0] column_address,
  output logic [ROW_W-1:0] row_address,
  output logic [ROW_W-1:0] row_address_active,
  output logic [BITS-1:0]  brightness_mask,
  output logic [BITS-1:0]  brightness_mask_active,
  output logic             pixel_load,
  output logic             clk_pixel,
  output logic             row_latch,
  output logic             output_enable,
  output logic             frame_start
);

  localparam int MAX_TICKS = BASE_TICKS << (BITS - 1);
  localparam int OE_W      = $clog2(MAX_TICKS + 1);
  localparam int PH_MAX    = (LATCH_CYCLES > BLANK_CYCLES) ? LATCH_CYCLES : BLANK_CYCLES;
  localparam int PH_W      = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT,
    ST_BLANK,
    ST_LATCH
  } state_t;

  state_t          state;
  logic [OE_W-1:0] oe_cnt;
  logic [PH_W-1:0] ph_cnt;
  logic [1:0]      shr;

`ifdef MATRIX_SCAN_DIM_EN
  assign shr = dim;
`else
  assign shr = 2'd0;
`endif

  // On-time for the plane selected by a one-hot mask, divided by 2^shr and
  // never shorter than one cycle.
  function automatic logic [OE_W-1:0] on_ticks(input logic [BITS-1:0] mask,
                                               input logic [1:0] div);
    logic [OE_W-1:0] t;
    t = '0;
    for (int p = 0; p < BITS; p++) begin
      if (mask[p]) t = OE_W'(BASE_TICKS << p);
    end
    t = t >> div;
    if (t == '0) t = OE_W'(1);
    return t;
  endfunction

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state                  <= ST_IDLE;
      oe_cnt                 <= '0;
      ph_cnt                 <= '0;
      column_address         <= COL_W'(COLUMNS - 1);
      row_address            <= '0;
      row_address_active     <= '0;
      brightness_mask        <= BITS'(1) << (BITS - 1);
      brightness_mask_active <= '0;
      pixel_load             <= 1'b0;
      clk_pixel              <= 1'b0;
      row_latch              <= 1'b0;
      output_enable          <= 1'b0;
      frame_start            <= 1'b0;
    end else begin
      frame_start <= 1'b0;

      // Display timer runs independently of the FSM. output_enable mirrors
      // "counter non-zero" one cycle ahead, so it is high for exactly the
      // loaded count.
      if (oe_cnt != '0) oe_cnt <= oe_cnt - OE_W'(1);
      output_enable <= (oe_cnt > OE_W'(1));

      case (state)
        ST_IDLE: begin
          if (enable) begin
            state          <= ST_SHIFT;
            column_address <= COL_W'(COLUMNS - 1);
            pixel_load     <= 1'b1;
            clk_pixel      <= 1'b0;
          end
        end

        // pixel_load doubles as the phase flag: high = phase A, low = phase B.
        ST_SHIFT: begin
          if (pixel_load) begin
            pixel_load <= 1'b0;
            clk_pixel  <= 1'b1;
          end else begin
            clk_pixel <= 1'b0;
            if (column_address == '0) begin
              state <= ST_WAIT;
            end else begin
              column_address <= column_address - COL_W'(1);
              pixel_load     <= 1'b1;
            end
          end
        end

        ST_WAIT: begin
          if (oe_cnt == '0) begin
            if (enable) begin
              state  <= ST_BLANK;
              ph_cnt <= PH_W'(BLANK_CYCLES - 1);
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        ST_BLANK: begin
          if (ph_cnt == '0) begin
            state     <= ST_LATCH;
            row_latch <= 1'b1;
            ph_cnt    <= PH_W'(LATCH_CYCLES - 1);
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end

        ST_LATCH: begin
          if (ph_cnt == '0) begin
            row_latch              <= 1'b0;
            row_address_active     <= row_address;
            brightness_mask_active <= brightness_mask;
            oe_cnt                 <= on_ticks(brightness_mask, shr);
            output_enable          <= 1'b1;
            frame_start            <= (row_address == '0) && brightness_mask[BITS-1];
            // Advance to the next plane; after plane 0 move to the next row.
            if (brightness_mask[0]) begin
              brightness_mask <= BITS'(1) << (BITS - 1);
              if (row_address == ROW_W'(ROWS - 1)) row_address <= '0;
              else                                 row_address <= row_address + ROW_W'(1);
            end else begin
              brightness_mask <= brightness_mask >> 1;
            end
            state          <= ST_SHIFT;
            column_address <= COL_W'(COLUMNS - 1);
            pixel_load     <= 1'b1;
            clk_pixel      <= 1'b0;
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_param.sv
// Testbench for matrix_scan_param: a default-sized instance (64x16x6, base 23)
// and a small instance (4 columns, 3 rows, 2 planes, base 2) are checked every
// cycle against a timeline model built from the scanning rules, plus literal
// expectations for pulse widths, latch timing and enable/reset behaviour.
module tb_matrix_scan_param;
  localparam int NK = 2600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en_a, en_b;

  logic [5:0] col_a;  logic [3:0] row_a, arow_a; logic [5:0] mask_a, amask_a;
  logic pl_a, ck_a, lat_a, oe_a, fs_a;
  logic [1:0] col_b;  logic [1:0] row_b, arow_b; logic [1:0] mask_b, amask_b;
  logic pl_b, ck_b, lat_b, oe_b, fs_b;
`ifdef MATRIX_SCAN_DIM_EN
  logic [1:0] dim_a = 2'd0, dim_b = 2'd0;
`endif

  matrix_scan_param dut_a (
    .clk_in(clk), .reset(rst), .enable(en_a),
`ifdef MATRIX_SCAN_DIM_EN
    .dim(dim_a),
`endif
    .column_address(col_a), .row_address(row_a), .row_address_active(arow_a),
    .brightness_mask(mask_a), .brightness_mask_active(amask_a),
    .pixel_load(pl_a), .clk_pixel(ck_a), .row_latch(lat_a),
    .output_enable(oe_a), .frame_start(fs_a)
  );

  matrix_scan_param #(.COLUMNS(4), .ROWS(3), .BITS(2), .BASE_TICKS(2)) dut_b (
    .clk_in(clk), .reset(rst), .enable(en_b),
`ifdef MATRIX_SCAN_DIM_EN
    .dim(dim_b),
`endif
    .column_address(col_b), .row_address(row_b), .row_address_active(arow_b),
    .brightness_mask(mask_b), .brightness_mask_active(amask_b),
    .pixel_load(pl_b), .clk_pixel(ck_b), .row_latch(lat_b),
    .output_enable(oe_b), .frame_start(fs_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int col, input int row, input int arow,
                                     input int mask, input int amask, input int pl,
                                     input int ck, input int lt, input int oe, input int fs);
    return {19'd0, col[7:0], row[7:0], arow[7:0], mask[7:0], amask[7:0],
            pl[0], ck[0], lt[0], oe[0], fs[0]};
  endfunction

  // Expected per-cycle outputs; index k = cycles after the first enabled edge.
  int e_col[2][NK], e_row[2][NK], e_arow[2][NK], e_mask[2][NK], e_amask[2][NK];
  int e_pl[2][NK], e_ck[2][NK], e_lat[2][NK], e_oe[2][NK], e_fs[2][NK];

  // Timeline model: each plane is a 2*C-cycle shift, then a wait until the
  // running display is over (at least one cycle), one blank cycle, one latch
  // cycle, then display of BASE<<plane cycles starting with the next shift.
  task automatic build(input int id, input int C, input int R, input int B, input int BASE);
    int t, tw, d, on, row, plane, oe_end;
    for (int k = 0; k < NK; k++) begin
      e_col[id][k] = C - 1; e_row[id][k] = 0; e_arow[id][k] = 0;
      e_mask[id][k] = 1 << (B - 1); e_amask[id][k] = 0;
      e_pl[id][k] = 0; e_ck[id][k] = 0; e_lat[id][k] = 0; e_oe[id][k] = 0; e_fs[id][k] = 0;
    end
    t = 0; oe_end = 0; row = 0; plane = B - 1;
    while (t < NK) begin
      for (int j = 0; j < 2 * C; j++) begin
        if (t + j < NK) begin
          e_pl[id][t+j]  = (j % 2 == 0);
          e_ck[id][t+j]  = (j % 2 == 1);
          e_col[id][t+j] = C - 1 - j / 2;
        end
      end
      for (int k = t + 2 * C; k < NK; k++) e_col[id][k] = 0;
      tw = (t + 2 * C > oe_end) ? t + 2 * C : oe_end;
      d  = tw + 3;
      if (tw + 2 < NK) e_lat[id][tw+2] = 1;
      on = BASE << plane;
      for (int k = d; k < d + on && k < NK; k++) e_oe[id][k] = 1;
      if (d < NK && row == 0 && plane == B - 1) e_fs[id][d] = 1;
      for (int k = d; k < NK; k++) begin
        e_arow[id][k] = row; e_amask[id][k] = 1 << plane;
      end
      if (plane == 0) begin
        plane = B - 1; row = (row + 1) % R;
      end else begin
        plane--;
      end
      for (int k = d; k < NK; k++) begin
        e_row[id][k] = row; e_mask[id][k] = 1 << plane;
      end
      oe_end = d + on;
      t = d;
    end
  endtask

  bit cmp_on = 0;
  int k = 0;
  int first_lat = -1, clk_cnt = 0, fs_cnt_a = 0, fs_cnt_b = 0, ovl = 0, w_a = 0;
  int widths_a[$];
  int rows_b[$];
  logic oe_b_d = 1'b0;

  always @(posedge clk) begin
    #1;
    if (cmp_on && k < NK) begin
      chk($sformatf("cycle_a_k%0d", k),
          pk(col_a, row_a, arow_a, mask_a, amask_a, pl_a, ck_a, lat_a, oe_a, fs_a),
          pk(e_col[0][k], e_row[0][k], e_arow[0][k], e_mask[0][k], e_amask[0][k],
             e_pl[0][k], e_ck[0][k], e_lat[0][k], e_oe[0][k], e_fs[0][k]));
      chk($sformatf("cycle_b_k%0d", k),
          pk(col_b, row_b, arow_b, mask_b, amask_b, pl_b, ck_b, lat_b, oe_b, fs_b),
          pk(e_col[1][k], e_row[1][k], e_arow[1][k], e_mask[1][k], e_amask[1][k],
             e_pl[1][k], e_ck[1][k], e_lat[1][k], e_oe[1][k], e_fs[1][k]));
      if (lat_a && first_lat < 0) first_lat = k;
      if (k < 128 && ck_a) clk_cnt++;
      if (fs_a) fs_cnt_a++;
      if (fs_b) fs_cnt_b++;
      k++;
    end
    if (!rst) begin
      if (oe_a) w_a++;
      else if (w_a > 0) begin
        widths_a.push_back(w_a);
        w_a = 0;
      end
      if ((oe_a && lat_a) || (oe_b && lat_b)) ovl++;
      if (oe_b && !oe_b_d && amask_b == 2'b10) rows_b.push_back(int'(arow_b));
      oe_b_d = oe_b;
    end else begin
      w_a = 0;
      oe_b_d = 1'b0;
    end
  end

  function automatic int getw(input int i);
    return (i < widths_a.size()) ? widths_a[i] : -1;
  endfunction

  function automatic int getr(input int i);
    return (i < rows_b.size()) ? rows_b[i] : -1;
  endfunction

  task automatic chk_reset_a(input string tag);
    chk({tag, "_col"},   col_a,   64'd63);
    chk({tag, "_row"},   row_a,   64'd0);
    chk({tag, "_arow"},  arow_a,  64'd0);
    chk({tag, "_mask"},  mask_a,  64'h20);
    chk({tag, "_amask"}, amask_a, 64'd0);
    chk({tag, "_ctl"},   {pl_a, ck_a, lat_a, oe_a, fs_a}, 64'd0);
  endtask

  int exp_w[7] = '{736, 368, 184, 92, 46, 23, 736};
  int exp_r[4] = '{0, 1, 2, 0};
  int quiet;

  initial begin
    build(0, 64, 16, 6, 23);
    build(1, 4, 3, 2, 2);
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_a("rst_a");
    chk("rst_b_col",  col_b,  64'd3);
    chk("rst_b_mask", mask_b, 64'h2);
    chk("rst_b_ctl",  {pl_b, ck_b, lat_b, oe_b, fs_b}, 64'd0);

    // Released but not enabled: must stay idle.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_enable", {pl_a, ck_a, pl_b, ck_b}, 64'd0);

    en_a = 1'b1; en_b = 1'b1; cmp_on = 1'b1;
    repeat (NK) @(negedge clk);
    cmp_on = 1'b0;

    chk("first_latch_k", first_lat, 64'd130);
    chk("first_shift_clk_pulses", clk_cnt, 64'd64);
    chk("frame_start_a_count", fs_cnt_a, 64'd1);
    chk("frame_start_b_count", fs_cnt_b, 64'd40);
    chk("latch_oe_overlap", ovl, 64'd0);
    for (int i = 0; i < 7; i++) chk($sformatf("oe_width_%0d", i), getw(i), exp_w[i]);
    for (int i = 0; i < 4; i++) chk($sformatf("rows3_active_%0d", i), getr(i), exp_r[i]);

    // Drop enable mid-shift: the running plane-4 display must complete, then idle.
    en_a = 1'b0;
    for (int i = 0; i < 1000 && oe_a; i++) @(negedge clk);
    chk("oe_fall_bounded", oe_a, 64'd0);
    repeat (5) @(negedge clk);
    quiet = 0;
    repeat (50) begin
      @(negedge clk);
      if (pl_a || ck_a || lat_a || oe_a) quiet++;
    end
    chk("idle_quiet", quiet, 64'd0);
    chk("drop_oe_width", getw(7), 64'd368);
    chk("drop_arow", arow_a, 64'd1);
    chk("drop_amask", amask_a, 64'h10);
    chk("pending_row", row_a, 64'd1);
    chk("pending_mask", mask_a, 64'h08);

    // Re-enable: re-shift the pending plane 3 of row 1.
    en_a = 1'b1;
    @(negedge clk);
    chk("resume_load", pl_a, 64'd1);
    chk("resume_col", col_a, 64'd63);
    for (int i = 0; i < 400 && !oe_a; i++) @(negedge clk);
    chk("resume_oe_rise", oe_a, 64'd1);
    chk("resume_amask", amask_a, 64'h08);
    chk("resume_arow", arow_a, 64'd1);
    for (int i = 0; i < 400 && oe_a; i++) @(negedge clk);
    chk("resume_oe_width", getw(8), 64'd184);
    for (int i = 0; i < 400 && !oe_a; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("mid_oe_before_reset", oe_a, 64'd1);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    chk_reset_a("midrst_a");
    chk("midrst_b_ctl", {lat_b, oe_b, fs_b}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
